// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Dirty victims are written back in 4-beat bursts before a 4-beat line refill.
module dcache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_done
);

  localparam int TAG_BITS  = ADDR_BITS - 2 - INDEX_BITS;
  localparam int LINES     = 1 << INDEX_BITS;
  localparam int WORD_BITS = INDEX_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_WB_WAIT, S_REFILL, S_REFILL_WAIT, S_DONE
  } state_e;

  state_e                 state_q;
  logic [1:0]             beat_q;
  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [LINES];
  logic [31:0]            data_q [2**WORD_BITS];
  logic [ADDR_BITS-1:0]   req_addr_q;
  logic                   req_we_q;
  logic [31:0]            req_wdata_q;
  logic [31:0]            cpu_rdata_q;
  logic                   cpu_ready_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [31:0]            mem_wdata_q;
  logic                   mem_write_q;
  logic                   mem_read_q;

  logic [INDEX_BITS-1:0]  cpu_idx, req_idx;
  logic [TAG_BITS-1:0]    cpu_tag, req_tag;
  logic [WORD_BITS-1:0]   cpu_word, req_word;
  logic [1:0]             beat_inc;
  logic                   hit;

  // The {index, offset} low address bits directly select a word in the line array.
  assign cpu_idx  = cpu_addr[WORD_BITS-1:2];
  assign cpu_tag  = cpu_addr[ADDR_BITS-1:WORD_BITS];
  assign cpu_word = cpu_addr[WORD_BITS-1:0];
  assign req_idx  = req_addr_q[WORD_BITS-1:2];
  assign req_tag  = req_addr_q[ADDR_BITS-1:WORD_BITS];
  assign req_word = req_addr_q[WORD_BITS-1:0];
  assign beat_inc = beat_q + 2'd1;
  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // NOTE: tag_q and data_q are deliberately left out of the reset branch; a line
  // is only ever read while its valid bit is set, so clearing them buys nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      cpu_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cpu_req) begin
          req_addr_q  <= cpu_addr;
          req_we_q    <= cpu_we;
          req_wdata_q <= cpu_wdata;
          beat_q      <= '0;
          if (hit) begin
            if (cpu_we) begin
              data_q[cpu_word] <= cpu_wdata;
              dirty_q[cpu_idx] <= 1'b1;
            end else begin
              cpu_rdata_q <= data_q[cpu_word];
            end
            cpu_ready_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (dirty_q[cpu_idx]) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= {tag_q[cpu_idx], cpu_idx, 2'b00};
            mem_wdata_q <= data_q[{cpu_idx, 2'b00}];
            state_q     <= S_WB;
          end else begin
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {cpu_tag, cpu_idx, 2'b00};
            state_q     <= S_REFILL;
          end
        end
        S_WB: begin
          if (beat_q == 2'd3) begin
            mem_write_q <= 1'b0;
            state_q     <= S_WB_WAIT;
          end else begin
            beat_q      <= beat_inc;
            mem_addr_q  <= {tag_q[req_idx], req_idx, beat_inc};
            mem_wdata_q <= data_q[{req_idx, beat_inc}];
          end
        end
        S_WB_WAIT: if (mem_done) begin
          beat_q     <= '0;
          mem_read_q <= 1'b1;
          mem_addr_q <= {req_tag, req_idx, 2'b00};
          state_q    <= S_REFILL;
        end
        S_REFILL: begin
          data_q[{req_idx, beat_q}] <= mem_rdata;
          if (beat_q == 2'd3) begin
            mem_read_q <= 1'b0;
            state_q    <= S_REFILL_WAIT;
          end else begin
            beat_q <= beat_inc;
          end
        end
        S_REFILL_WAIT: if (mem_done) begin
          tag_q[req_idx]   <= req_tag;
          valid_q[req_idx] <= 1'b1;
          // A store miss merges its word into the fresh line, leaving it dirty.
          dirty_q[req_idx] <= req_we_q;
          if (req_we_q) data_q[req_word] <= req_wdata_q;
          else          cpu_rdata_q      <= data_q[req_word];
          cpu_ready_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign mem_read  = mem_read_q;

endmodule
